// File: rtl/ecc_ladder_core.sv
// ecc_ladder_core: GF(2^M) Montgomery-ladder scalar multiplier in Lopez-Dahab coordinates with a shared bit-serial multiplier
module ecc_ladder_core #(
    parameter int M = 163,
    parameter logic [M-1:0] POLY = 163'hC9,
    parameter int OUT_W = 176
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ecc_start,
    input  logic             ecc_abort,
    input  logic [M-1:0]     g,
    input  logic [M-1:0]     b,
    input  logic [M-1:0]     k,
    output logic [OUT_W-1:0] ecc_outxa,
    output logic [OUT_W-1:0] ecc_outza,
    output logic [OUT_W-1:0] ecc_outxb,
    output logic [OUT_W-1:0] ecc_outzb,
    output logic             ecc_busy,
    output logic             ecc_done,
    output logic             ecc_inf
);
    localparam int IW = $clog2(M);
    localparam int PW = $clog2(M + 1);
    typedef enum logic [2:0] {IDLE, SCAN, INIT, STEP, DONE} state_t;
    state_t st, st_n;
    logic [M-1:0] gr, br, kr, x1, z1, x2, z2, t1, t2, acc, a_sh, acc_n, opa, opb;
    logic [M-1:0] nx1, nz1, nx2, nz2, nt1, nt2, xa, za, xb, zb;
    logic [IW-1:0] idx, msb;
    logic [PW-1:0] ph;
    logic [3:0] op;
    logic inf, kb, mul, last, wr;
    assign mul = st == INIT || st == STEP;
    assign last = ph == PW'(M);
    assign wr = mul && last && !ecc_abort;
    assign kb = kr[idx - IW'(1)];
    assign xa = kb ? x1 : x2;
    assign za = kb ? z1 : z2;
    assign xb = kb ? x2 : x1;
    assign zb = kb ? z2 : z1;
    assign acc_n = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0) ^ (a_sh[M-1] ? opb : '0);
    always_comb begin
        msb = '0;
        for (int n = 0; n < M; n++) if (kr[n]) msb = IW'(n);
    end
    always_comb begin
        opa = '0;
        opb = '0;
        if (st == INIT) begin
            opa = op[0] ? z2 : gr;
            opb = opa;
        end else if (st == STEP)
            case (op)
                4'd0: begin opa = xa; opb = zb; end
                4'd1: begin opa = xb; opb = za; end
                4'd2: begin opa = t1 ^ t2; opb = t1 ^ t2; end
                4'd3: begin opa = gr; opb = za; end
                4'd4, 4'd7: begin opa = t1; opb = t2; end
                4'd5: begin opa = xb; opb = xb; end
                4'd6: begin opa = zb; opb = zb; end
                4'd8: begin opa = t1; opb = t1; end
                4'd9: begin opa = t2; opb = t2; end
                4'd10: begin opa = br; opb = t1; end
                default: ;
            endcase
    end
    always_comb begin
        nx1 = x1;
        nz1 = z1;
        nx2 = x2;
        nz2 = z2;
        nt1 = t1;
        nt2 = t2;
        if (st == SCAN && !ecc_abort) begin
            nx1 = kr == '0 ? '0 : gr;
            nz1 = M'(kr != '0);
            if (kr == '0) begin
                nx2 = gr;
                nz2 = M'(1);
            end
        end else if (wr && st == INIT) begin
            if (op[0]) nx2 = acc_n ^ br;
            else nz2 = acc_n;
        end else if (wr)
            case (op)
                4'd0, 4'd5, 4'd9: nt1 = acc_n;
                4'd1, 4'd6: nt2 = acc_n;
                4'd2: if (kb) nz1 = acc_n; else nz2 = acc_n;
                4'd3: if (kb) nx1 = acc_n; else nx2 = acc_n;
                4'd4: if (kb) nx1 = acc_n ^ x1; else nx2 = acc_n ^ x2;
                4'd7: if (kb) nz2 = acc_n; else nz1 = acc_n;
                4'd8: if (kb) nx2 = acc_n; else nx1 = acc_n;
                4'd10: if (kb) nx2 = acc_n ^ x2; else nx1 = acc_n ^ x1;
                default: ;
            endcase
    end
    always_comb begin
        st_n = st;
        case (st)
            IDLE: st_n = ecc_start ? SCAN : IDLE;
            SCAN: st_n = kr == '0 ? DONE : INIT;
            INIT: if (last && op[0]) st_n = idx == '0 ? DONE : STEP;
            STEP: if (last && op == 4'd11 && idx == IW'(1)) st_n = DONE;
            default: st_n = IDLE;
        endcase
        if (ecc_abort && st != IDLE) st_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else st <= st_n;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {gr, br, kr, x1, z1, x2, z2, t1, t2, acc, a_sh} <= '0;
            idx <= '0;
            ph <= '0;
            op <= '0;
            inf <= 1'b0;
        end else begin
            {x1, z1, x2, z2, t1, t2} <= {nx1, nz1, nx2, nz2, nt1, nt2};
            if (st == IDLE && ecc_start) begin
                gr <= g;
                br <= b;
                kr <= k;
                inf <= 1'b0;
            end
            if (st == SCAN) begin
                idx <= msb;
                ph <= '0;
                op <= '0;
                inf <= kr == '0 && !ecc_abort;
            end
            if (mul) begin
                ph <= last ? '0 : ph + 1'b1;
                acc <= ph == '0 ? '0 : acc_n;
                a_sh <= ph == '0 ? opa : a_sh << 1;
                if (last) begin
                    op <= (st == INIT && op[0]) || op == 4'd11 ? '0 : op + 1'b1;
                    if (st == STEP && op == 4'd11) idx <= idx - 1'b1;
                end
            end
        end
    end
    assign ecc_outxa = OUT_W'(x1);
    assign ecc_outza = OUT_W'(z1);
    assign ecc_outxb = OUT_W'(x2);
    assign ecc_outzb = OUT_W'(z2);
    assign ecc_busy = st != IDLE;
    assign ecc_done = st == DONE;
    assign ecc_inf = inf;
endmodule
